// File: rtl/count_pkg.sv
// Shared types and default sizing for the counter snapshot FIFO.
package count_pkg;

  localparam int CNT_W     = 8;
  localparam int DEPTH_DEF = 4;
  localparam int TOT_W_DEF = 16;

  typedef struct packed {
    logic             is_ovf;
    logic [CNT_W-1:0] value;
  } snap_entry_t;

endpackage

// File: rtl/count_snapshot_fifo_if.sv
// Valid/ready read channel carrying snapshot entries out of the FIFO.
interface count_snapshot_fifo_if #(
  parameter int WIDTH = 8
);

  logic             rd_valid_out;
  logic             rd_ready_in;
  logic [WIDTH:0]   rd_data_out;

  modport master (output rd_valid_out, output rd_data_out, input rd_ready_in);
  modport slave  (input rd_valid_out, input rd_data_out, output rd_ready_in);

endinterface

// File: rtl/snap_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop while full frees room
// for a push in the same cycle.
module snap_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              pop_ok;
  logic              push_ok;

  assign valid_o = (level_q != LVL_W'(0));
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & valid_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      level_q  <= LVL_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Captures counter snapshots on overflow edges and capture strobes into a
// FWFT FIFO, and keeps saturating overflow and drop totals.
module count_snapshot_fifo
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TOT_W = TOT_W_DEF,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk_in,
  input  logic                  nrst_in,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  ovf_in,
  input  logic                  capture_in,
  count_snapshot_fifo_if.master rd,
  output logic [LVL_W-1:0]      level_out,
  output logic                  full_out,
  output logic [TOT_W-1:0]      ovf_total_out,
  output logic [7:0]            dropped_out
);

  logic             ovf_q;
  logic [TOT_W-1:0] ovf_total_q, ovf_total_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             ovf_ev;
  logic             req;
  logic             pop;
  logic             push;
  logic             drop;

  assign ovf_ev = ovf_in & ~ovf_q;
  assign req    = ovf_ev | capture_in;
  assign pop    = rd.rd_valid_out & rd.rd_ready_in;
  assign push   = req & (~full_out | pop);
  assign drop   = req & full_out & ~pop;

  snap_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (nrst_in),
    .push_i  (push),
    .data_i  ({ovf_ev, cnt_in}),
    .pop_i   (pop),
    .data_o  (rd.rd_data_out),
    .valid_o (rd.rd_valid_out),
    .full_o  (full_out),
    .level_o (level_out)
  );

  // Saturating totals: both stick at all-ones.
  always_comb begin
    ovf_total_d = ovf_total_q;
    dropped_d   = dropped_q;
    if (ovf_ev && (ovf_total_q != {TOT_W{1'b1}})) begin
      ovf_total_d = ovf_total_q + TOT_W'(1);
    end else begin
      ovf_total_d = ovf_total_q;
    end
    if (drop && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end else begin
      dropped_d = dropped_q;
    end
  end

  // Edge-detect register and totals.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      ovf_q       <= 1'b0;
      ovf_total_q <= TOT_W'(0);
      dropped_q   <= 8'd0;
    end else begin
      ovf_q       <= ovf_in;
      ovf_total_q <= ovf_total_d;
      dropped_q   <= dropped_d;
    end
  end

  assign ovf_total_out = ovf_total_q;
  assign dropped_out   = dropped_q;

endmodule

// File: doc/count_snapshot_fifo.md
Name: count_snapshot_fifo

Overview:
- Sits downstream of the 8-bit up/down counter and consumes its counter value and overflow flag.
- Records a snapshot of the count on every overflow event and on software capture strobes.
- Buffers snapshots in a small first-word-fall-through FIFO, read out through a valid/ready handshake.
- Keeps saturating totals of overflow events and of snapshots dropped because the FIFO was full.

Parameters:
WIDTH  8  width of the counter value being sampled
DEPTH  4  FIFO entries; power of two, >= 2
TOT_W  16  width of the overflow-total counter

Ports:
clk_in  input  1  clock, all state on rising edge
nrst_in  input  1  asynchronous active-low reset
cnt_in  input  WIDTH  counter value (driven from counter_out)
ovf_in  input  1  overflow flag (driven from ovf_out)
capture_in  input  1  software snapshot request, level; one request per cycle high
rd_ready_in  input  1  consumer ready
rd_valid_out  output  1  head entry valid
rd_data_out  output  WIDTH+1  head entry: bit WIDTH = is_ovf, bits [WIDTH-1:0] = captured count
level_out  output  $clog2(DEPTH)+1  number of stored entries
full_out  output  1  level_out == DEPTH
ovf_total_out  output  TOT_W  saturating count of overflow events
dropped_out  output  8  saturating count of lost snapshots

Behaviour:
- Interface: one clock, clk_in; reset nrst_in is asynchronous, active-low.
- Reset: pointers, level_out, ovf_total_out and dropped_out go to 0; rd_valid_out=0, full_out=0; ovf edge register goes to 0. rd_data_out is don't-care while rd_valid_out=0.
- Overflow event (ovf_ev): ovf_ev = ovf_in & ~ovf_q, where ovf_q is ovf_in registered.
  - A level held high counts once.
  - If ovf_in is 1 in the first cycle after reset release, that counts as an event.
- Snapshot request: req = ovf_ev | capture_in.
  - Stored entry = {ovf_ev, cnt_in}, sampled in the same cycle as req.
  - If ovf_ev and capture_in coincide, one entry is written with is_ovf=1.
- Pop: pop = rd_valid_out & rd_ready_in.
  - rd_valid_out = (level_out != 0).
  - rd_data_out is the head entry, combinationally from storage (FWFT).
- Push: push = req & (~full_out | pop).
  - When full, a simultaneous pop makes room; the push is accepted and level stays DEPTH.
- Empty case: a push into an empty FIFO shows rd_valid_out=1 on the next cycle. There is no same-cycle bypass; read latency is 1 cycle.
- Level update: level_out += push - pop. Pointers wrap modulo DEPTH.
- Drop: req & full_out & ~pop increments dropped_out, saturating at 255. The entry is lost.
- Overflow total: each ovf_ev increments ovf_total_out, saturating at 2^TOT_W-1, whether or not the entry was stored.
- Illegal pop: rd_ready_in while empty has no effect.
- Reset mid-operation: all state clears immediately (asynchronous); buffered entries are discarded.

Decomposition:
- Shared package count_pkg holds:
  - typedef snap_entry_t: packed struct {logic is_ovf; logic [WIDTH-1:0] value}.
  - Default constants for DEPTH and TOT_W.
- One sub-module, snap_fifo: generic sync FWFT FIFO with push/pop, full/level outputs and simultaneous push/pop when full.
- Top level holds edge detect, request merge, saturating counters and drop logic.

Test Plan:
- Reset then idle: hold nrst_in=0 -> rd_valid_out=0, level_out=0, ovf_total_out=0, dropped_out=0.
- Single capture: cnt_in=8'h5A, capture_in=1 for 1 cycle -> next cycle rd_valid_out=1, rd_data_out=9'h05A; pop with rd_ready_in=1 -> level_out=0.
- Overflow level held: ovf_in=1 for 3 cycles with cnt_in=8'hFF -> exactly one entry 9'h1FF, ovf_total_out=1.
- Coincident events: ovf_in rises while capture_in=1, cnt_in=8'h00 -> one entry 9'h100, level_out=1.
- Overflow past full: 6 capture cycles, rd_ready_in=0, DEPTH=4 -> full_out=1, level_out=4, dropped_out=2, first entry retained. Then capture with rd_ready_in=1 while full -> level stays 4, dropped_out unchanged.
- Saturation and async reset: force 300 drops -> dropped_out=255. Assert nrst_in mid-stream without a clock edge -> all outputs 0 immediately.
